// File: rtl/obi_pkg.sv
// Shared OBI field widths and arbiter state encoding, reused across the interconnect.
package obi_pkg;
  localparam int unsigned OBI_ADDR_WIDTH = 32;
  localparam int unsigned OBI_DATA_WIDTH = 32;
  localparam int unsigned OBI_BE_WIDTH   = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/obi_rr_arbiter_if.sv
// Bundle of the N-master request side and the single downstream slave port.
interface obi_rr_arbiter_if #(
  parameter int MASTERS = 3
);
  import obi_pkg::*;

  logic                      master_req_i   [MASTERS];
  logic                      master_we_i    [MASTERS];
  logic [OBI_BE_WIDTH-1:0]   master_be_i    [MASTERS];
  logic [OBI_ADDR_WIDTH-1:0] master_addr_i  [MASTERS];
  logic [OBI_DATA_WIDTH-1:0] master_wdata_i [MASTERS];
  logic                      master_gnt_o   [MASTERS];
  logic                      master_rvalid_o[MASTERS];
  logic [OBI_DATA_WIDTH-1:0] master_rdata_o [MASTERS];

  logic                      slave_req_o;
  logic                      slave_we_o;
  logic [OBI_BE_WIDTH-1:0]   slave_be_o;
  logic [OBI_ADDR_WIDTH-1:0] slave_addr_o;
  logic [OBI_DATA_WIDTH-1:0] slave_wdata_o;
  logic                      slave_gnt_i;
  logic                      slave_rvalid_i;
  logic [OBI_DATA_WIDTH-1:0] slave_rdata_i;

  // Arbiter side: it is the bus slave of the masters and drives the downstream port.
  modport slave (
    input  master_req_i, master_we_i, master_be_i, master_addr_i, master_wdata_i,
    output master_gnt_o, master_rvalid_o, master_rdata_o,
    output slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o,
    input  slave_gnt_i, slave_rvalid_i, slave_rdata_i
  );

  // Environment side: upstream masters plus the downstream memory.
  modport master (
    output master_req_i, master_we_i, master_be_i, master_addr_i, master_wdata_i,
    input  master_gnt_o, master_rvalid_o, master_rdata_o,
    input  slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o,
    output slave_gnt_i, slave_rvalid_i, slave_rdata_i
  );
endinterface

// File: rtl/obi_rr_arbiter_fifo.sv
// Small in-order FIFO of issuing master indices; head is visible combinationally.
module obi_rr_arbiter_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_BITS = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_reg [DEPTH];
  logic [PTR_BITS-1:0] wptr_reg;
  logic [PTR_BITS-1:0] rptr_reg;
  logic [CNT_BITS-1:0] count_reg;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wptr_reg] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= ptr_inc(wptr_reg);
      if (pop)  rptr_reg <= ptr_inc(rptr_reg);
      if (push && !pop)      count_reg <= count_reg + CNT_BITS'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_BITS'(1);
    end
  end

  assign rdata = mem_reg[rptr_reg];
  assign full  = (count_reg == CNT_BITS'(DEPTH));
  assign empty = (count_reg == '0);
endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin N:1 OBI arbiter with request locking and an in-order response index FIFO.
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int MASTERS         = 3,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MASTER_BITS     = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  obi_rr_arbiter_if.slave  bus,
  output logic             err_o
);
  arb_state_e             state_reg, state_next;
  logic [MASTER_BITS-1:0] last_ptr_reg, last_ptr_next;
  logic [MASTER_BITS-1:0] lock_idx_reg, lock_idx_next;
  logic                   err_reg, err_next;
  logic [MASTER_BITS-1:0] sel;
  logic [MASTER_BITS-1:0] head;
  logic                   sel_req, slave_req, handshake, pop;
  logic                   fifo_full, fifo_empty;

  // Rotating search from last_ptr+1; a locked request keeps its index regardless of priority.
  always_comb begin : select_p
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = last_ptr_reg;
    if (state_reg == LOCKED) begin
      sel = lock_idx_reg;
    end else begin
      for (int i = 1; i <= MASTERS; i++) begin
        idx = (int'(last_ptr_reg) + i) % MASTERS;
        if (!found && bus.master_req_i[idx]) begin
          sel   = MASTER_BITS'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign sel_req   = bus.master_req_i[sel];
  // No same-cycle bypass: a pop does not free a slot for an issue in that cycle.
  assign slave_req = rst_ni && sel_req && !fifo_full;
  assign handshake = slave_req && bus.slave_gnt_i;
  assign pop       = rst_ni && bus.slave_rvalid_i && !fifo_empty;

  assign bus.slave_req_o   = slave_req;
  assign bus.slave_we_o    = bus.master_we_i[sel];
  assign bus.slave_be_o    = bus.master_be_i[sel];
  assign bus.slave_addr_o  = bus.master_addr_i[sel];
  assign bus.slave_wdata_o = bus.master_wdata_i[sel];

  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
      assign bus.master_gnt_o[gi]    = handshake && (sel == MASTER_BITS'(gi));
      assign bus.master_rvalid_o[gi] = pop && (head == MASTER_BITS'(gi));
      assign bus.master_rdata_o[gi]  = bus.slave_rdata_i;
    end
  endgenerate

  obi_rr_arbiter_fifo #(
    .WIDTH (MASTER_BITS),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (pop),
    .wdata  (sel),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_next    = state_reg;
    last_ptr_next = last_ptr_reg;
    lock_idx_next = lock_idx_reg;
    err_next      = err_reg;
    if (bus.slave_rvalid_i && fifo_empty) err_next = 1'b1;
    unique case (state_reg)
      ARB: begin
        if (handshake) begin
          last_ptr_next = sel;
        end else if (slave_req) begin
          state_next    = LOCKED;
          lock_idx_next = sel;
        end
      end
      LOCKED: begin
        // A master withdrawing an ungranted request breaks the OBI handshake rules.
        if (!sel_req) begin
          err_next   = 1'b1;
          state_next = ARB;
        end else if (handshake) begin
          last_ptr_next = sel;
          state_next    = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= ARB;
      last_ptr_reg <= MASTER_BITS'(MASTERS - 1);
      lock_idx_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_ptr_reg <= last_ptr_next;
      lock_idx_reg <= lock_idx_next;
      err_reg      <= err_next;
    end
  end

  assign err_o = err_reg;
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench: vector table, directed lock/reset sequences and random traffic vs a queue model.
module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int M    = 3;
  localparam int MAXO = 2;

  logic clk_i;
  logic rst_ni;
  logic err_o;

  obi_rr_arbiter_if #(.MASTERS(M)) bus ();

  obi_rr_arbiter #(
    .MASTERS         (M),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .err_o  (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  bit [M-1:0]  req_v;
  bit [M-1:0]  we_v;
  logic [31:0] addr_v  [M];
  logic [31:0] wdata_v [M];
  logic [3:0]  be_v    [M];
  bit          sgnt;
  bit          srv;
  bit          rst_v;
  logic [31:0] rdata_v;

  // Reference model: priority pointer, lock flag and a queue of issuers in order
  int  m_last;
  bit  m_locked;
  int  m_lock;
  int  m_q[$];
  bit  m_err;
  bit [M-1:0] e_gnt, e_rv;
  bit  e_sreq;
  int  e_sel;

  typedef struct {
    bit [2:0] req;
    bit       sgnt;
    bit       srv;
    bit [2:0] gnt;
    bit       sreq;
    bit [2:0] rv;
    bit       err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(bit [2:0] rq, bit g, bit rv_in, bit [2:0] eg, bit es, bit [2:0] erv, bit ee);
    vec_t v;
    v.req = rq; v.sgnt = g; v.srv = rv_in; v.gnt = eg; v.sreq = es; v.rv = erv; v.err = ee;
    return v;
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_last   = M - 1;
    m_locked = 1'b0;
    m_lock   = 0;
    m_q.delete();
    m_err    = 1'b0;
  endfunction

  function automatic void model_eval();
    e_gnt = '0; e_rv = '0; e_sreq = 1'b0; e_sel = 0;
    if (!rst_v) return;
    if (m_locked) e_sel = m_lock;
    else begin
      for (int k = 1; k <= M; k++) begin
        if (req_v[(m_last + k) % M]) begin
          e_sel = (m_last + k) % M;
          break;
        end
      end
    end
    e_sreq = req_v[e_sel] && (m_q.size() < MAXO);
    if (e_sreq && sgnt) e_gnt[e_sel] = 1'b1;
    if (srv && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
  endfunction

  function automatic void model_commit();
    if (!rst_v) begin
      model_reset();
      return;
    end
    if (srv) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (m_locked && !req_v[m_lock]) begin
      m_err    = 1'b1;
      m_locked = 1'b0;
    end else if (e_sreq && sgnt) begin
      m_last   = e_sel;
      m_q.push_back(e_sel);
      m_locked = 1'b0;
    end else if (e_sreq) begin
      m_locked = 1'b1;
      m_lock   = e_sel;
    end
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < M; i++) begin
      addr_v[i]  = $urandom;
      wdata_v[i] = $urandom;
      be_v[i]    = 4'($urandom_range(0, 15));
      we_v[i]    = 1'($urandom_range(0, 1));
    end
    rdata_v = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      bus.master_req_i[i]   = req_v[i];
      bus.master_we_i[i]    = we_v[i];
      bus.master_be_i[i]    = be_v[i];
      bus.master_addr_i[i]  = addr_v[i];
      bus.master_wdata_i[i] = wdata_v[i];
    end
    bus.slave_gnt_i    = sgnt;
    bus.slave_rvalid_i = srv;
    bus.slave_rdata_i  = rdata_v;
    rst_ni             = rst_v;
  endtask

  function automatic bit [M-1:0] dut_gnt();
    bit [M-1:0] g;
    for (int i = 0; i < M; i++) g[i] = bus.master_gnt_o[i];
    return g;
  endfunction

  function automatic bit [M-1:0] dut_rv();
    bit [M-1:0] r;
    for (int i = 0; i < M; i++) r[i] = bus.master_rvalid_o[i];
    return r;
  endfunction

  // One clock: drive, compare against the model at negedge, advance the model at posedge.
  // want_gnt: -2 no extra check, -1 no grant expected, else the index that must be granted.
  task automatic cycle(input string tag, input int want_gnt);
    bit [M-1:0] g, r;
    rand_payload();
    drive();
    model_eval();
    @(negedge clk_i);
    g = dut_gnt();
    r = dut_rv();
    chk({tag, "_gnt"}, 32'(g), 32'(e_gnt));
    chk({tag, "_rvalid"}, 32'(r), 32'(e_rv));
    chk({tag, "_sreq"}, 32'(bus.slave_req_o), 32'(e_sreq));
    chk({tag, "_err"}, 32'(err_o), 32'(m_err));
    for (int i = 0; i < M; i++) chk({tag, "_rdata"}, bus.master_rdata_o[i], rdata_v);
    if (e_sreq) begin
      chk({tag, "_addr"}, bus.slave_addr_o, addr_v[e_sel]);
      chk({tag, "_wdata"}, bus.slave_wdata_o, wdata_v[e_sel]);
      chk({tag, "_be"}, 32'(bus.slave_be_o), 32'(be_v[e_sel]));
      chk({tag, "_we"}, 32'(bus.slave_we_o), 32'(we_v[e_sel]));
    end
    if (want_gnt != -2)
      chk({tag, "_want_gnt"}, 32'(g), (want_gnt < 0) ? 32'd0 : (32'd1 << want_gnt));
    $display("cyc %-8s rst=%0b req=%b sgnt=%0b srv=%0b gnt=%b rv=%b sreq=%0b err=%0b",
             tag, rst_v, req_v, sgnt, srv, g, r, bus.slave_req_o, err_o);
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  task automatic set_in(input bit r, input bit [M-1:0] rq, input bit g, input bit v);
    rst_v = r; req_v = rq; sgnt = g; srv = v;
  endtask

  initial begin
    model_reset();
    set_in(1'b0, '1, 1'b0, 1'b1);
    rand_payload();
    drive();

    // Reset with activity on the inputs: outputs must stay quiet
    cycle("reset", -1);
    cycle("reset", -1);

    // Vector table: rotation, push/pop overlap, full backpressure, spurious rvalid
    tbl[0]  = mk(3'b111, 1, 0, 3'b001, 1, 3'b000, 0);
    tbl[1]  = mk(3'b111, 1, 1, 3'b010, 1, 3'b001, 0);
    tbl[2]  = mk(3'b111, 1, 1, 3'b100, 1, 3'b010, 0);
    tbl[3]  = mk(3'b111, 1, 1, 3'b001, 1, 3'b100, 0);
    tbl[4]  = mk(3'b111, 1, 1, 3'b010, 1, 3'b001, 0);
    tbl[5]  = mk(3'b111, 1, 1, 3'b100, 1, 3'b010, 0);
    tbl[6]  = mk(3'b000, 1, 1, 3'b000, 0, 3'b100, 0);
    tbl[7]  = mk(3'b000, 1, 0, 3'b000, 0, 3'b000, 0);
    tbl[8]  = mk(3'b001, 1, 0, 3'b001, 1, 3'b000, 0);
    tbl[9]  = mk(3'b001, 1, 0, 3'b001, 1, 3'b000, 0);
    tbl[10] = mk(3'b001, 1, 0, 3'b000, 0, 3'b000, 0);
    tbl[11] = mk(3'b001, 1, 1, 3'b000, 0, 3'b001, 0);
    tbl[12] = mk(3'b001, 1, 0, 3'b001, 1, 3'b000, 0);
    tbl[13] = mk(3'b000, 1, 1, 3'b000, 0, 3'b001, 0);
    tbl[14] = mk(3'b000, 1, 1, 3'b000, 0, 3'b001, 0);
    tbl[15] = mk(3'b000, 1, 1, 3'b000, 0, 3'b000, 0);
    tbl[16] = mk(3'b000, 1, 0, 3'b000, 0, 3'b000, 1);

    for (int n = 0; n < 17; n++) begin
      bit [M-1:0] g, r;
      set_in(1'b1, tbl[n].req, tbl[n].sgnt, tbl[n].srv);
      rand_payload();
      drive();
      model_eval();
      @(negedge clk_i);
      g = dut_gnt();
      r = dut_rv();
      chk($sformatf("vec%0d_gnt", n), 32'(g), 32'(tbl[n].gnt));
      chk($sformatf("vec%0d_sreq", n), 32'(bus.slave_req_o), 32'(tbl[n].sreq));
      chk($sformatf("vec%0d_rvalid", n), 32'(r), 32'(tbl[n].rv));
      chk($sformatf("vec%0d_err", n), 32'(err_o), 32'(tbl[n].err));
      $display("vec %0d req=%b gnt=%b rv=%b sreq=%0b err=%0b", n, tbl[n].req, g, r, bus.slave_req_o, err_o);
      @(posedge clk_i);
      model_commit();
      #1;
    end

    // One-cycle reset clears the sticky error
    set_in(1'b0, '0, 1'b0, 1'b0); cycle("rst_err", -1);
    set_in(1'b1, '0, 1'b0, 1'b0); cycle("post_rst", -1);

    // Lock: master 1 stalled, master 0 (now higher priority) must wait
    set_in(1'b1, 3'b010, 1'b0, 1'b0); cycle("lock_a", -1);
    set_in(1'b1, 3'b011, 1'b0, 1'b0); cycle("lock_b", -1);
    set_in(1'b1, 3'b011, 1'b0, 1'b0); cycle("lock_c", -1);
    set_in(1'b1, 3'b011, 1'b1, 1'b0); cycle("lock_hs", 1);
    set_in(1'b1, 3'b011, 1'b1, 1'b0); cycle("after", 0);
    set_in(1'b1, 3'b000, 1'b0, 1'b1); cycle("drain", -1);
    set_in(1'b1, 3'b000, 1'b0, 1'b1); cycle("drain", -1);

    // Locked master withdraws its request
    set_in(1'b1, 3'b100, 1'b0, 1'b0); cycle("viol_a", -1);
    set_in(1'b1, 3'b000, 1'b0, 1'b0); cycle("viol_b", -1);
    set_in(1'b1, 3'b000, 1'b0, 1'b0); cycle("viol_c", -1);
    set_in(1'b0, 3'b000, 1'b0, 1'b0); cycle("rst", -1);

    // Reset with two transactions outstanding
    set_in(1'b1, 3'b001, 1'b1, 1'b0); cycle("os_1", 0);
    set_in(1'b1, 3'b001, 1'b1, 1'b0); cycle("os_2", 0);
    set_in(1'b0, 3'b111, 1'b1, 1'b1); cycle("os_rst", -1);
    set_in(1'b1, 3'b111, 1'b1, 1'b1); cycle("os_prio", 0);
    set_in(1'b1, 3'b000, 1'b0, 1'b0); cycle("os_err", -1);
    set_in(1'b0, 3'b000, 1'b0, 1'b0); cycle("rst", -1);

    // Random traffic, mostly protocol-compliant
    for (int n = 0; n < 400; n++) begin
      bit [M-1:0] rq;
      rq = M'($urandom_range(0, (1 << M) - 1));
      if (m_locked) rq[m_lock] = ($urandom_range(0, 31) != 0);
      srv = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      set_in((n != 200), rq, 1'($urandom_range(0, 1)), srv);
      cycle("rand", -2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
